// File: rtl/fp_div_result_queue_if.sv
// Bundles the divider issue/return, consumer dequeue and status signals of the FP divide result queue.
// Latency: none; this file carries wires only.
// Backpressure: credit-based on the issue side (issue_ready) and valid/ready on the dequeue side.
interface fp_div_result_queue_if #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
);
    // Issue side: a division launches on issue_valid & issue_ready
    logic          issue_valid;
    logic          issue_ready;

    // Return side: one beat per divider valid_data_out, never stalled
    logic          res_valid;
    logic [31:0]   res_data;
    logic [4:0]    res_flags;

    // Consumer side
    logic          deq_valid;
    logic          deq_ready;
    logic [31:0]   deq_data;
    logic [4:0]    deq_flags;

    // Status
    logic [4:0]    fflags;
    logic          fflags_clr;
    logic [CW-1:0] occupancy;
    logic [CW-1:0] inflight;
    logic          err;

    // The queue itself
    modport slave (
        input  issue_valid, res_valid, res_data, res_flags, deq_ready, fflags_clr,
        output issue_ready, deq_valid, deq_data, deq_flags, fflags, occupancy, inflight, err
    );

    // The surrounding logic: issuer, divider return and consumer
    modport master (
        output issue_valid, res_valid, res_data, res_flags, deq_ready, fflags_clr,
        input  issue_ready, deq_valid, deq_data, deq_flags, fflags, occupancy, inflight, err
    );
endinterface

// File: rtl/fp_div_result_queue.sv
// Credit-controlled result FIFO behind a non-stalling FP divider, with sticky IEEE flags (FP_DIV_RESULT_QUEUE_STICKY_FLAGS_EN).
// Latency: a return is visible on deq_* one cycle later; a pop releases a credit one cycle later.
// Backpressure: issue_ready withholds launches when stored + in-flight results would exceed DEPTH; deq side is valid/ready.
module fp_div_result_queue #(
    parameter int DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_div_result_queue_if.slave q
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [CW:0]   FULL_X  = (CW + 1)'(DEPTH);

    typedef struct packed {
        logic [4:0]  flags;
        logic [31:0] data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic          err_q, err_d;

    logic          issue_ready;
    logic          launch;
    logic          bad_launch;
    logic          store;
    logic          pop;
    logic          inflight_dec;
    logic [CW:0]   credit_used;
    entry_t        head;

    // Credits in use are everything stored plus everything still inside the divider
    assign credit_used = {1'b0, count_q} + {1'b0, inflight_q};
    assign issue_ready = ~rst & (credit_used < FULL_X);

    assign launch       = q.issue_valid & issue_ready;
    assign bad_launch   = q.issue_valid & ~issue_ready;
    // Space is judged on the pre-pop count, so a return at full is dropped even with a pop
    assign store        = q.res_valid & (count_q != FULL);
    // A return with nothing in flight is still stored but must not wrap the counter
    assign inflight_dec = store & (inflight_q != '0);
    assign pop          = q.deq_valid & q.deq_ready;

    assign head        = mem_q[rd_ptr_q];
    assign q.issue_ready = issue_ready;
    assign q.deq_valid   = (count_q != '0);
    assign q.deq_data    = head.data;
    assign q.deq_flags   = head.flags;
    assign q.occupancy   = count_q;
    assign q.inflight    = inflight_q;
    assign q.err         = err_q;

    // Next-state for storage, pointers, counters and the sticky error
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        err_d      = err_q;

        if (store) begin
            mem_d[wr_ptr_q] = '{flags: q.res_flags, data: q.res_data};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (store && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!store && pop) begin
            count_d = count_q - CW'(1);
        end

        if (launch && !inflight_dec) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!launch && inflight_dec) begin
            inflight_d = inflight_q - CW'(1);
        end

        if (bad_launch || (q.res_valid && (count_q == FULL)) ||
            (q.res_valid && (inflight_q == '0))) begin
            err_d = 1'b1;
        end
    end

    // State registers; reset flushes everything, including results still in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

`ifdef FP_DIV_RESULT_QUEUE_STICKY_FLAGS_EN
    logic [4:0] fflags_q, fflags_d;

    // Clear first, then OR in the flags of a stored return so clear+accumulate keeps the new flags
    always_comb begin
        fflags_d = q.fflags_clr ? 5'b0 : fflags_q;
        if (store) begin
            fflags_d = fflags_d | q.res_flags;
        end
    end

    // Sticky flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= fflags_d;
        end
    end

    assign q.fflags = fflags_q;
`else
    logic unused_fflags_clr;

    assign unused_fflags_clr = q.fflags_clr;
    assign q.fflags          = '0;
`endif

endmodule
